// File: rtl/shift_engine_if.sv
// Handshake and data bundle for shift_engine.
// The master drives the start and operands; the slave returns the register state.
interface shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, din, serial_in,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  start, mode, amount, din, serial_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/shift_engine.sv
// Sequential shift/rotate engine: loads a word on start, then applies one step
// of the latched mode per clock for a programmable count.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic           clock,
  input  logic           reset,
  shift_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       mode_reg, mode_next;
  logic             serial_out_reg, serial_out_next;
  logic [WIDTH-1:0] step_q;
  logic             step_out;
  logic             accept;

  // A start is only honoured outside SHIFT; DONE accepts it for back-to-back ops.
  assign accept = bus.start && (state_reg != ST_SHIFT);

  // State register and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      q_reg          <= '0;
      count_reg      <= '0;
      mode_reg       <= 3'd0;
      serial_out_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      q_reg          <= q_next;
      count_reg      <= count_next;
      mode_reg       <= mode_next;
      serial_out_reg <= serial_out_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_next = (bus.amount == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_reg <= CNT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One step of the latched mode; HOLD modes keep both q and the exit bit.
  always_comb begin
    step_q   = q_reg;
    step_out = serial_out_reg;
    case (mode_reg)
      3'b000: begin
        step_q   = {q_reg[WIDTH-2:0], bus.serial_in};
        step_out = q_reg[WIDTH-1];
      end
      3'b001: begin
        step_q   = {bus.serial_in, q_reg[WIDTH-1:1]};
        step_out = q_reg[0];
      end
      3'b010: begin
        step_q   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        step_out = q_reg[WIDTH-1];
      end
      3'b011: begin
        step_q   = {q_reg[0], q_reg[WIDTH-1:1]};
        step_out = q_reg[0];
      end
      3'b100: begin
        step_q   = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
        step_out = q_reg[0];
      end
      default: begin
        step_q   = q_reg;
        step_out = serial_out_reg;
      end
    endcase
  end

  // Datapath next values
  always_comb begin
    q_next          = q_reg;
    count_next      = count_reg;
    mode_next       = mode_reg;
    serial_out_next = serial_out_reg;
    if (accept) begin
      q_next          = bus.din;
      count_next      = bus.amount;
      mode_next       = bus.mode;
      serial_out_next = 1'b0;
    end else if (state_reg == ST_SHIFT) begin
      q_next          = step_q;
      serial_out_next = step_out;
      count_next      = count_reg - 1'b1;
    end
  end

  // Output logic
  assign bus.busy       = (state_reg == ST_SHIFT);
  assign bus.done       = (state_reg == ST_DONE);
  assign bus.q          = q_reg;
  assign bus.serial_out = serial_out_reg;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: vector table, hand-written corner
// sequences and randomized operations against a closed-form reference model.
module tb_shift_engine;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  shift_engine_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]    mode;
    logic [CW-1:0] amount;
    logic [W-1:0]  din;
    logic          si;
    logic [W-1:0]  exp_q;
    logic          exp_so;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Final result of an operation computed directly from the step rules.
  function automatic void model(input logic [2:0] m, input int n, input logic [W-1:0] d,
                                input logic si, output logic [W-1:0] mq, output logic mso);
    logic [W-1:0]        ones;
    logic signed [W-1:0] sd;
    int                  r;
    ones = '1;
    sd   = $signed(d);
    r    = n % W;
    mq   = d;
    mso  = 1'b0;
    if (n != 0) begin
      case (m)
        3'b000: begin
          if (n >= W) begin
            mq  = si ? ones : '0;
            mso = (n == W) ? d[0] : si;
          end else begin
            mq  = (d << n) | (si ? ~(ones << n) : '0);
            mso = d[W-n];
          end
        end
        3'b001: begin
          if (n >= W) begin
            mq  = si ? ones : '0;
            mso = (n == W) ? d[W-1] : si;
          end else begin
            mq  = (d >> n) | (si ? ~(ones >> n) : '0);
            mso = d[n-1];
          end
        end
        3'b010: begin
          mq  = (d << r) | (d >> (W - r));
          mso = mq[0];
        end
        3'b011: begin
          mq  = (d >> r) | (d << (W - r));
          mso = mq[W-1];
        end
        3'b100: begin
          mq  = sd >>> n;
          mso = (n >= W) ? d[W-1] : d[n-1];
        end
        default: begin
          mq  = d;
          mso = 1'b0;
        end
      endcase
    end
  endfunction

  // Runs one complete operation from IDLE, scrambling operands during SHIFT.
  task automatic do_op(input string name, input logic [2:0] m, input logic [CW-1:0] amt,
                       input logic [W-1:0] d, input logic si,
                       input logic [W-1:0] exp_q, input logic exp_so);
    int n_busy;
    bus.start = 1'b1; bus.mode = m; bus.amount = amt; bus.din = d; bus.serial_in = si;
    tick();
    bus.start = 1'b0;
    check({name, ".load_q"}, 32'(bus.q), 32'(d));
    n_busy = 0;
    while (bus.busy && n_busy < 100) begin
      n_busy++;
      bus.start  = 1'($urandom_range(0, 1));
      bus.mode   = 3'($urandom);
      bus.amount = CW'($urandom);
      bus.din    = W'($urandom);
      tick();
    end
    bus.start = 1'b0;
    check({name, ".busy_cycles"}, 32'(n_busy), 32'(amt));
    check({name, ".done"}, 32'(bus.done), 32'd1);
    check({name, ".q"}, 32'(bus.q), 32'(exp_q));
    check({name, ".serial_out"}, 32'(bus.serial_out), 32'(exp_so));
    $display("op %s mode=%0d amt=%0d din=%02h si=%0d -> q=%02h so=%0d busy_cycles=%0d",
             name, m, amt, d, si, bus.q, bus.serial_out, n_busy);
    tick();
    check({name, ".done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  logic [W-1:0] shl_q  [3];
  logic         shl_so [3];

  initial begin
    vecs[0] = '{3'b000, 4'd3,  8'h81, 1'b1, 8'h0F, 1'b0};
    vecs[1] = '{3'b011, 4'd9,  8'h01, 1'b0, 8'h80, 1'b1};
    vecs[2] = '{3'b100, 4'd2,  8'h90, 1'b0, 8'hE4, 1'b0};
    vecs[3] = '{3'b010, 4'd4,  8'hA5, 1'b0, 8'h5A, 1'b0};
    vecs[4] = '{3'b001, 4'd4,  8'hF0, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{3'b001, 4'd8,  8'hFF, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{3'b101, 4'd3,  8'hC3, 1'b1, 8'hC3, 1'b0};
    vecs[7] = '{3'b111, 4'd0,  8'h77, 1'b0, 8'h77, 1'b0};
    vecs[8] = '{3'b100, 4'd15, 8'h7F, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{3'b010, 4'd1,  8'h80, 1'b0, 8'h01, 1'b1};
    shl_q  = '{8'h03, 8'h07, 8'h0F};
    shl_so = '{1'b1, 1'b0, 1'b0};

    // Reset dominates a simultaneous start
    bus.start = 1'b1; bus.mode = 3'b000; bus.amount = 4'd3; bus.din = 8'hFF; bus.serial_in = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset.q", 32'(bus.q), 32'h00);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      check("reset.serial_out", 32'(bus.serial_out), 32'd0);
      $display("reset edge %0d: q=%02h busy=%0d done=%0d", i, bus.q, bus.busy, bus.done);
    end
    reset = 1'b0; bus.start = 1'b0;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].amount, vecs[i].din,
            vecs[i].si, vecs[i].exp_q, vecs[i].exp_so);
    end

    // SHL step-by-step sequence
    bus.start = 1'b1; bus.mode = 3'b000; bus.amount = 4'd3; bus.din = 8'h81; bus.serial_in = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("shl_seq.busy", 32'(bus.busy), 32'd1);
      tick();
      check($sformatf("shl_seq.q%0d", i), 32'(bus.q), 32'(shl_q[i]));
      check($sformatf("shl_seq.so%0d", i), 32'(bus.serial_out), 32'(shl_so[i]));
      $display("shl step %0d: q=%02h so=%0d", i, bus.q, bus.serial_out);
    end
    check("shl_seq.done", 32'(bus.done), 32'd1);
    tick();

    // Zero amount followed by a back-to-back start held during DONE
    bus.start = 1'b1; bus.mode = 3'b000; bus.amount = 4'd0; bus.din = 8'h5A; bus.serial_in = 1'b0;
    tick();
    check("zero.q", 32'(bus.q), 32'h5A);
    check("zero.done", 32'(bus.done), 32'd1);
    check("zero.busy", 32'(bus.busy), 32'd0);
    bus.din = 8'h01; bus.amount = 4'd1;
    tick();
    bus.start = 1'b0;
    check("b2b.load_q", 32'(bus.q), 32'h01);
    check("b2b.busy", 32'(bus.busy), 32'd1);
    check("b2b.done_low", 32'(bus.done), 32'd0);
    tick();
    check("b2b.q", 32'(bus.q), 32'h02);
    check("b2b.done", 32'(bus.done), 32'd1);
    $display("back-to-back: q=%02h done=%0d", bus.q, bus.done);
    tick();
    check("b2b.idle", 32'(bus.done), 32'd0);

    // Ignored start during SHIFT, then reset abort
    bus.start = 1'b1; bus.mode = 3'b001; bus.amount = 4'd5; bus.din = 8'hF0; bus.serial_in = 1'b0;
    tick();
    bus.din = 8'h00;
    tick();
    bus.start = 1'b0;
    check("ignore.q", 32'(bus.q), 32'h78);
    check("ignore.busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.q", 32'(bus.q), 32'h00);
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort.no_done", 32'(bus.done), 32'd0);
      check("abort.no_busy", 32'(bus.busy), 32'd0);
    end
    $display("reset abort: q=%02h busy=%0d done=%0d", bus.q, bus.busy, bus.done);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]    m;
      logic [CW-1:0] a;
      logic [W-1:0]  d, mq;
      logic          si, mso;
      m  = 3'($urandom);
      a  = CW'($urandom);
      d  = W'($urandom);
      si = 1'($urandom);
      model(m, int'(a), d, si, mq, mso);
      do_op($sformatf("rnd%0d", i), m, a, d, si, mq, mso);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised sequential shift/rotate engine. It is the multi-bit successor to the single-bit D flip-flop: a WIDTH-bit register that loads a word and then shifts or rotates it one bit per clock for a programmable count. A start/busy/done handshake drives each operation. It serves as the datapath register for serial-conversion and bit-manipulation labs built on the flip-flop primitives.

## Interface
Parameters:
- WIDTH, default 8: data register width (≥ 2).
- CNT_W, default 4: width of the shift-amount port. Amounts 0 to 2^CNT_W−1 are legal.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high. Takes priority over every other input.
- start, input, 1: begins an operation when sampled high in IDLE or DONE.
- mode, input, 3: operation select, sampled only at the accepted start.
- amount, input, CNT_W: number of single-bit steps, sampled only at the accepted start.
- din, input, WIDTH: word loaded into q at the accepted start.
- serial_in, input, 1: fill bit for SHL/SHR, sampled live on every shift edge.
- q, output, WIDTH: register contents.
- serial_out, output, 1: registered copy of the bit most recently shifted or rotated out.
- busy, output, 1: high while in SHIFT.
- done, output, 1: one-cycle pulse, high while in DONE.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: q = 0, serial_out = 0, busy = 0, done = 0, internal count = 0, latched mode = 0.
- Accepted start (state IDLE or DONE, start = 1):
  - q ← din, count ← amount, mode latched, serial_out ← 0.
  - If amount > 0, go to SHIFT; if amount = 0, go to DONE.
- start in SHIFT is ignored. It is not queued.
- SHIFT, on each edge: apply one step of the latched mode, set serial_out to the exiting bit, and decrement count. When count = 1 before the step, go to DONE.
- DONE: lasts one cycle. Returns to IDLE unless start is high, in which case the start is accepted (back-to-back operation).
- IDLE: q and serial_out hold.
- Modes (single step):
  - 000 SHL: q ← {q[W−2:0], serial_in}, out = q[W−1].
  - 001 SHR: q ← {serial_in, q[W−1:1]}, out = q[0].
  - 010 ROL: out = q[W−1].
  - 011 ROR: out = q[0].
  - 100 ASR: q ← {q[W−1], q[W−1:1]}, out = q[0].
  - 101–111 HOLD: q unchanged, serial_out unchanged. Count still decrements, so timing matches the other modes.
- Amounts greater than WIDTH are legal. Steps simply repeat: rotations wrap modulo WIDTH, and logical shifts flush fully to serial_in.
- Changes to mode, amount or din during SHIFT have no effect.

## Timing
- Start sampled at edge E0. After E0, q = din.
- If amount = N > 0: busy is high from after E0 through after E(N−1). The final step occurs at EN. After EN, q holds the final value, busy = 0 and done = 1 for exactly one cycle.
- If amount = 0: done = 1 in the cycle after E0, and busy never rises.
- Start-to-done latency is N+1 edges, counting E0.
- The earliest next start is sampled at the edge that ends DONE.
- Reset at any edge, including mid-SHIFT or during DONE: all registers take their reset values at that edge. done does not pulse for the aborted operation.
- Reset and start high at the same edge: reset wins.

## Test plan
- Reset: hold reset for 2 edges with start = 1 and din = 0xFF. Expect q = 0x00, busy = 0, done = 0, serial_out = 0 throughout.
- SHL with fill: din = 0x81, amount = 3, mode = 000, serial_in = 1.
  - q sequence: 0x03, 0x07, 0x0F.
  - serial_out sequence: 1, 0, 0.
  - busy high for 3 cycles, then done high for 1 cycle.
- ROR wrap: din = 0x01, amount = 9, mode = 011.
  - Final q = 0x80, serial_out = 1.
  - busy high for 9 cycles.
- ASR sign extension: din = 0x90, amount = 2, mode = 100. Final q = 0xE4, serial_out = 0.
- Zero amount and back-to-back:
  - First op: amount = 0, din = 0x5A. q = 0x5A, done pulses the cycle after start, busy stays 0.
  - Hold start high during DONE with din = 0x01, amount = 1, mode = 000, serial_in = 0. Expect q = 0x02 and a second done pulse.
- Ignored start and reset abort:
  - Start SHR with din = 0xF0, amount = 5.
  - Pulse start with din = 0x00 during the first shift cycle. It must be ignored: the next q is 0x78 with serial_in = 0.
  - Assert reset at the 2nd shift edge. Expect q = 0x00, busy = 0, and no done pulse.
